// File: rtl/uart_rx_frame_module.sv
// 8N1 UART receiver: mid-bit sampling, frame/break handling and tracking of the
// transmitter's extended stop gap that closes each block of BLOCK_LEN bytes.
module uart_rx_frame_module #(
   parameter int CLK_DIV   = 434,
   parameter int BLOCK_LEN = 1638,
   parameter int GAP_BITS  = 5
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        RX_Pin_In,
   input  logic        en_RX,
   output logic [7:0]  RX_Data,
   output logic        RX_Done_Sig,
   output logic        Frame_Err,
   output logic        Block_End_Sig,
   output logic        Gap_Err,
   output logic [10:0] Byte_Count
);

   localparam int               GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [15:0]      BIT_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0]      HALF_LAST = 16'(CLK_DIV / 2 - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
   localparam logic [10:0]      BLOCK_CNT = 11'(BLOCK_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [15:0]      timer_q, timer_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [10:0]      byte_count_q, byte_count_d;
   logic             rx_done_q, rx_done_d;
   logic             frame_err_q, frame_err_d;
   logic             block_end_q, block_end_d;
   logic             gap_err_q, gap_err_d;

   logic             rx_sync;
   logic             start_edge;
   logic [15:0]      timer_inc;
   logic [10:0]      byte_count_inc;

   // sync_q[1] is the synchronized line; sync_q[2] is its previous-cycle copy.
   assign sync_d         = {sync_q[1:0], RX_Pin_In};
   assign rx_sync        = sync_q[1];
   assign start_edge     = sync_q[2] & ~sync_q[1];
   assign timer_inc      = (timer_q == BIT_LAST) ? 16'd0 : timer_q + 16'd1;
   assign byte_count_inc = byte_count_q + 11'd1;

   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d      = state_q;
      timer_d      = timer_inc;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      gap_cnt_d    = gap_cnt_q;
      rx_data_d    = rx_data_q;
      byte_count_d = byte_count_q;
      rx_done_d    = 1'b0;
      frame_err_d  = 1'b0;
      block_end_d  = 1'b0;
      gap_err_d    = 1'b0;

      if (!en_RX) begin
         state_d = S_IDLE;
         timer_d = 16'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               timer_d = 16'd0;
               if (start_edge) state_d = S_START;
            end
            S_START: begin
               if (timer_q == HALF_LAST) begin
                  timer_d   = 16'd0;
                  bit_idx_d = 3'd0;
                  state_d   = rx_sync ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (timer_q == BIT_LAST) begin
                  shift_d   = {rx_sync, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (timer_q == BIT_LAST) begin
                  if (rx_sync) begin
                     rx_data_d    = shift_q;
                     rx_done_d    = 1'b1;
                     byte_count_d = byte_count_inc;
                     gap_cnt_d    = '0;
                     state_d      = (byte_count_inc == BLOCK_CNT) ? S_GAP : S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               timer_d = 16'd0;
               if (rx_sync) state_d = S_IDLE;
            end
            S_GAP: begin
               // An early start edge is a real byte, so it goes straight to START.
               if (start_edge) begin
                  gap_err_d    = 1'b1;
                  byte_count_d = 11'd0;
                  timer_d      = 16'd0;
                  state_d      = S_START;
               end else if (!rx_sync) begin
                  timer_d   = 16'd0;
                  gap_cnt_d = '0;
               end else if (timer_q == BIT_LAST) begin
                  if (gap_cnt_q == GAP_LAST) begin
                     block_end_d  = 1'b1;
                     byte_count_d = 11'd0;
                     state_d      = S_IDLE;
                  end else begin
                     gap_cnt_d = gap_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Synchronizer resets to the idle-high line level so reset release is not an edge.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= S_IDLE;
         sync_q       <= 3'b111;
         timer_q      <= 16'd0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'd0;
         gap_cnt_q    <= '0;
         rx_data_q    <= 8'd0;
         byte_count_q <= 11'd0;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         block_end_q  <= 1'b0;
         gap_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         sync_q       <= sync_d;
         timer_q      <= timer_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         gap_cnt_q    <= gap_cnt_d;
         rx_data_q    <= rx_data_d;
         byte_count_q <= byte_count_d;
         rx_done_q    <= rx_done_d;
         frame_err_q  <= frame_err_d;
         block_end_q  <= block_end_d;
         gap_err_q    <= gap_err_d;
      end
   end

   assign RX_Data       = rx_data_q;
   assign RX_Done_Sig   = rx_done_q;
   assign Frame_Err     = frame_err_q;
   assign Block_End_Sig = block_end_q;
   assign Gap_Err       = gap_err_q;
   assign Byte_Count    = byte_count_q;

endmodule

// File: tb/tb_uart_rx_frame_module.sv
// Bench for uart_rx_frame_module: directed scenarios plus random frames, compared
// against an event-list model derived from bit-period arithmetic.
module tb_uart_rx_frame_module;

   localparam int CLK_DIV   = 16;
   localparam int BLOCK_LEN = 4;
   localparam int GAP_BITS  = 5;
   localparam int DET_LAT   = 2;
   localparam int DONE_OFS  = DET_LAT + CLK_DIV / 2 + 9 * CLK_DIV + 1;
   localparam int GAP_CYC   = GAP_BITS * CLK_DIV;

   localparam int K_DONE = 0;
   localparam int K_FERR = 1;
   localparam int K_BEND = 2;
   localparam int K_GERR = 3;

   typedef struct {
      int          kind;
      int          cyc;
      logic [7:0]  data;
      logic [10:0] cnt;
   } ev_t;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b1;
   logic        rx_pin = 1'b1;
   logic        en_rx  = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        frame_err;
   logic        block_end;
   logic        gap_err;
   logic [10:0] byte_count;

   int          cyc      = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_multi  = 0;
   ev_t         exp_q[$];
   ev_t         obs_q[$];

   int          model_count = 0;
   logic [7:0]  model_data  = 8'd0;
   bit          gap_pending = 1'b0;
   int          gap_end_cyc = 0;

   uart_rx_frame_module #(
      .CLK_DIV  (CLK_DIV),
      .BLOCK_LEN(BLOCK_LEN),
      .GAP_BITS (GAP_BITS)
   ) dut (
      .CLK          (clk),
      .RSTn         (rst_n),
      .RX_Pin_In    (rx_pin),
      .en_RX        (en_rx),
      .RX_Data      (rx_data),
      .RX_Done_Sig  (rx_done),
      .Frame_Err    (frame_err),
      .Block_End_Sig(block_end),
      .Gap_Err      (gap_err),
      .Byte_Count   (byte_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic record(input int kind);
      ev_t e;
      e.kind = kind;
      e.cyc  = cyc;
      e.data = rx_data;
      e.cnt  = byte_count;
      obs_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if ((32'(rx_done) + 32'(frame_err) + 32'(block_end) + 32'(gap_err)) > 1) n_multi++;
      if (rx_done)   record(K_DONE);
      if (frame_err) record(K_FERR);
      if (block_end) record(K_BEND);
      if (gap_err)   record(K_GERR);
   end

   task automatic push_exp(input int kind, input int c, input logic [7:0] d, input logic [10:0] n);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.data = d;
      e.cnt  = n;
      exp_q.push_back(e);
   endtask

   // A start edge detected at cycle det settles any pending block gap.
   task automatic model_edge(input int det);
      if (gap_pending) begin
         if (det <= gap_end_cyc - 1) push_exp(K_GERR, det + 1, model_data, 11'd0);
         else                        push_exp(K_BEND, gap_end_cyc, model_data, 11'd0);
         gap_pending = 1'b0;
         model_count = 0;
      end
   endtask

   task automatic model_frame(input int n0, input logic [7:0] d, input bit stop_ok);
      if (stop_ok) begin
         model_count++;
         model_data = d;
         push_exp(K_DONE, n0 + DONE_OFS, d, 11'(model_count));
         if (model_count == BLOCK_LEN) begin
            gap_pending = 1'b1;
            gap_end_cyc = n0 + DONE_OFS + GAP_CYC;
         end
      end else begin
         push_exp(K_FERR, n0 + DONE_OFS, model_data, 11'(model_count));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx_pin = 1'b1;
      end
   endtask

   task automatic hold_low(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx_pin = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_data"},  32'(rx_data),    32'h0);
      check({tag, "_count"}, 32'(byte_count), 32'h0);
      check({tag, "_done"},  32'(rx_done),    32'h0);
      check({tag, "_ferr"},  32'(frame_err),  32'h0);
      check({tag, "_bend"},  32'(block_end),  32'h0);
      check({tag, "_gerr"},  32'(gap_err),    32'h0);
   endtask

   // baud is the bit length in percent of CLK_DIV; abort_at/rst_at are pin-cycle offsets (-1 = none).
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int baud,
                             input int abort_at, input int rst_at);
      int len;
      int n0;
      int b;
      len = (10 * CLK_DIV * baud + 99) / 100;
      n0  = 0;
      for (int t = 0; t < len; t++) begin
         @(posedge clk); #1;
         if (t == 0) n0 = cyc;
         b = (t * 100) / (CLK_DIV * baud);
         if (b == 0)      rx_pin = 1'b0;
         else if (b <= 8) rx_pin = d[b-1];
         else             rx_pin = stop_ok;
         if (t == abort_at) en_rx = 1'b0;
         if (t == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals("midframe_rst");
         end
      end
      model_edge(n0 + DET_LAT);
      if (rst_at >= 0) begin
         model_count = 0;
         model_data  = 8'd0;
         gap_pending = 1'b0;
      end else if (abort_at < 0) begin
         model_frame(n0, d, stop_ok);
      end
   endtask

   task automatic glitch(input int width);
      int n0;
      n0 = 0;
      for (int t = 0; t < width; t++) begin
         @(posedge clk); #1;
         if (t == 0) n0 = cyc;
         rx_pin = 1'b0;
      end
      idle(1);
      model_edge(n0 + DET_LAT);
   endtask

   task automatic flush_gap();
      idle(GAP_CYC + 40);
      model_edge(cyc + 1000000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      en_rx = 1'b1;
      idle(5);

      send_frame(8'hA5, 1'b1, 100, -1, -1);
      check("a5_data",  32'(rx_data),    32'hA5);
      check("a5_count", 32'(byte_count), 32'd1);

      send_frame(8'h00, 1'b1, 100, -1, -1);
      send_frame(8'hFF, 1'b1, 100, -1, -1);
      send_frame(8'h55, 1'b1, 100, -1, -1);
      check("b2b_count", 32'(byte_count), 32'd4);
      flush_gap();
      check("block_count", 32'(byte_count), 32'd0);
      check("block_data",  32'(rx_data),    32'h55);

      send_frame(8'h3C, 1'b0, 100, -1, -1);
      hold_low(40);
      check("ferr_data",  32'(rx_data),    32'h55);
      check("ferr_count", 32'(byte_count), 32'd0);
      idle(20);

      glitch(4);
      idle(20);
      send_frame(8'h81, 1'b1, 100, -1, -1);
      check("glitch_data",  32'(rx_data),    32'h81);
      check("glitch_count", 32'(byte_count), 32'd1);

      send_frame(8'h12, 1'b1, 100, -1, -1);
      send_frame(8'h34, 1'b1, 100, -1, -1);
      send_frame(8'h56, 1'b1, 100, -1, -1);
      idle(48);
      send_frame(8'h96, 1'b1, 100, -1, -1);
      check("gerr_data",  32'(rx_data),    32'h96);
      check("gerr_count", 32'(byte_count), 32'd1);

      flush_gap();
      send_frame(8'h5A, 1'b1, 100, 88, -1);
      idle(10);
      en_rx = 1'b1;
      check("abort_data",  32'(rx_data),    32'h96);
      check("abort_count", 32'(byte_count), 32'd1);
      idle(5);
      send_frame(8'hC3, 1'b1, 100, -1, -1);
      check("after_abort_data",  32'(rx_data),    32'hC3);
      check("after_abort_count", 32'(byte_count), 32'd2);

      send_frame(8'h77, 1'b1, 100, 70 - 70 - 1, 70);
      idle(10);
      rst_n = 1'b1;
      idle(5);
      send_frame(8'h1E, 1'b1, 100, -1, -1);
      check("after_rst_data",  32'(rx_data),    32'h1E);
      check("after_rst_count", 32'(byte_count), 32'd1);

      for (int i = 0; i < 40; i++) begin
         int sel;
         int baud;
         int r;
         sel  = $urandom_range(0, 3);
         baud = 97 + 3 * $urandom_range(0, 2);
         r    = $urandom_range(0, 9);
         case (sel)
            0:       idle(0);
            1:       idle($urandom_range(1, 30));
            2:       idle(48);
            default: idle(120);
         endcase
         if (r == 0) begin
            glitch($urandom_range(1, 5));
            idle(20);
         end else if (r == 1) begin
            send_frame(8'($urandom), 1'b0, baud, -1, -1);
            hold_low(40);
            idle(20);
         end else begin
            send_frame(8'($urandom), 1'b1, baud, -1, -1);
         end
      end
      flush_gap();
      check("final_count", 32'(byte_count), 32'(model_count));
      check("final_data",  32'(rx_data),    32'(model_data));

      check("event_total", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("ev%0d_kind", i),  32'(obs_q[i].kind), 32'(exp_q[i].kind));
         check($sformatf("ev%0d_cycle", i), 32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
         check($sformatf("ev%0d_data", i),  32'(obs_q[i].data), 32'(exp_q[i].data));
         check($sformatf("ev%0d_count", i), 32'(obs_q[i].cnt),  32'(exp_q[i].cnt));
      end
      check("single_pulse_cycles", 32'(n_multi), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_module.md
# uart_rx_frame_module

Serial receive side of the board's UART link, and the far-end counterpart of the byte transmitter. It samples the incoming line at mid-bit and deframes 8N1 characters: start low, 8 data bits LSB-first, stop high. Each valid byte is presented with a one-cycle strobe. It also tracks the transmitter's block structure: every BLOCK_LEN bytes the transmitter holds the line idle for an extended stop gap, and this block checks that gap and flags the block boundary for the downstream packet assembler.

## Interface
Parameters:
- CLK_DIV, 434: CLK cycles per bit period; legal range 8..65535.
- BLOCK_LEN, 1638: number of valid bytes per block.
- GAP_BITS, 5: idle bit periods required after the last byte of a block.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  reset, asynchronous, active-low.
- RX_Pin_In  in  1  serial line, asynchronous to CLK, idle high.
- en_RX  in  1  receive enable; low forces IDLE.
- RX_Data  out  8  last valid byte; held until the next valid byte.
- RX_Done_Sig  out  1  one-cycle pulse when a new byte is on RX_Data.
- Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.
- Block_End_Sig  out  1  one-cycle pulse when a block closes with a correct gap.
- Gap_Err  out  1  one-cycle pulse when a start edge arrives before the gap completes.
- Byte_Count  out  11  valid bytes received so far in the current block.

## Operation
- Input path: 2-FF synchronizer, then a third register for edge detection. A start edge is synchronized high in the previous cycle and low in the current cycle.
- Bit timer: 16-bit counter, cleared on state entry, wraps at CLK_DIV-1.
- IDLE: wait for a start edge while en_RX=1, then go to START.
- START: wait CLK_DIV/2 cycles (integer divide) and re-sample the line.
  - Low: go to DATA with bit index 0.
  - High: treat as a glitch and return to IDLE. No flags are raised.
- DATA: sample every CLK_DIV cycles into a shift register, LSB first. After bit 7, go to STOP.
- STOP: sample after CLK_DIV cycles.
  - High: load RX_Data, pulse RX_Done_Sig, increment Byte_Count.
    - If the new count equals BLOCK_LEN, go to GAP.
    - Otherwise go to IDLE.
  - Low: pulse Frame_Err, leave RX_Data and Byte_Count unchanged, go to BREAK.
- BREAK: wait for the synchronized line to be high, then go to IDLE. A line that stays low never produces a start edge.
- GAP: count full bit periods of continuous high line.
  - Any low sample restarts the count.
  - Reaching GAP_BITS periods: pulse Block_End_Sig, set Byte_Count to 0, go to IDLE.
  - A start edge first: pulse Gap_Err, set Byte_Count to 0, go to START. That edge is the start of the next byte.
- en_RX low in any state: go to IDLE on the next cycle and drop any partial byte. Byte_Count and RX_Data are held.
- At most one of RX_Done_Sig, Frame_Err, Block_End_Sig, Gap_Err is high in any cycle.

## Timing
- Reset values:
  - State IDLE; synchronizer registers 1.
  - RX_Data = 0, Byte_Count = 0.
  - RX_Done_Sig, Frame_Err, Block_End_Sig, Gap_Err = 0.
- Cycle numbering: cycle 0 is the cycle the synchronized edge is detected (2-3 CLK after the pin falls).
- Sample points:
  - Start bit: cycle H = CLK_DIV/2.
  - Data bit k: cycle H + (k+1)·CLK_DIV.
  - Stop bit: cycle H + 9·CLK_DIV.
- RX_Done_Sig or Frame_Err is registered in the cycle after the stop sample.
- RX_Data and Byte_Count update in the same cycle as RX_Done_Sig.
- Block_End_Sig asserts GAP_BITS·CLK_DIV cycles after GAP entry, given the line stays high.
- Back-to-back frames: a start edge is accepted in the first cycle of IDLE, so stop-to-next-start with zero idle time is supported.
- Tolerance: baud mismatch up to ±3% is received correctly.

## Test plan
Run with CLK_DIV=16, BLOCK_LEN=4, GAP_BITS=5.
- Byte 0xA5 sent at exact baud:
  - RX_Data=0xA5 with a single RX_Done_Sig pulse.
  - Pulse occurs at cycle 8+144+1 after detect.
  - Byte_Count=1.
- Bytes 0x00, 0xFF, 0x55 sent back-to-back with zero idle:
  - Three RX_Done_Sig pulses spaced exactly 160 cycles apart.
  - Values in order 0x00, 0xFF, 0x55.
- 0x3C sent with the stop bit forced low, line held low for 40 cycles:
  - Frame_Err pulses once.
  - RX_Data and Byte_Count unchanged.
  - No new start is accepted until the line returns high.
- 4-cycle low glitch on an idle line:
  - No pulses; state returns to IDLE.
  - A following valid 0x81 is received correctly.
- 4 bytes then 80 idle cycles:
  - Block_End_Sig pulses 80 cycles after the 4th RX_Done_Sig.
  - Byte_Count goes to 0.
  - Repeat with the 5th start sent 48 cycles after the 4th byte: Gap_Err pulses, Byte_Count=0, and the 5th byte is received with Byte_Count=1.
- en_RX dropped during bit 4 of a frame, and separately RSTn pulsed mid-frame:
  - No RX_Done_Sig for the interrupted frame.
  - Outputs return to their reset values on RSTn.
  - The next full frame is received normally.
